// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared states, widths and BCD helpers for the frequency gate controller
package freq_meter_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        SETTLE,
        LATCH,
        HOLD
    } state_t;

    localparam int BCD_DIGITS = 6;
    localparam int Q_W = BCD_DIGITS * 4;
    localparam logic [3:0] NIBBLE_MAX = 4'd9;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic logic bcd_ok(input logic [Q_W-1:0] q);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (q[i*4 +: 4] > NIBBLE_MAX) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/gate_timer.sv
// rtl/gate_timer.sv - loadable down-counter that parks at zero
module gate_timer #(
    parameter int W = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         LD,
    input  logic [W-1:0] LD_VAL,
    output logic         ZERO
);

    logic [W-1:0] cnt;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cnt <= '0;
        end else if (LD) begin
            cnt <= LD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign ZERO = (cnt == '0);

endmodule

// File: rtl/freq_gate_ctrl.sv
// rtl/freq_gate_ctrl.sv - clear/gate/settle/latch sequencer for a 6-digit BCD counter
// Optional BCD validation of the captured count: FREQ_GATE_BCD_CHECK_EN
module freq_gate_ctrl
    import freq_meter_pkg::*;
#(
    parameter int CLR_CYCLES    = 4,
    parameter int GATE_CYCLES   = 80,
    parameter int SETTLE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 10
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           START,
    input  logic [Q_W-1:0] Q_IN,
    output logic           ENA,
    output logic           CLR,
    output logic           LOAD,
    output logic [Q_W-1:0] Q_LATCH,
    output logic           VALID,
    output logic           BUSY,
    output logic           ERR
);

    localparam int TMAX = max4(CLR_CYCLES, GATE_CYCLES, SETTLE_CYCLES, HOLD_CYCLES);
    localparam int TW   = $clog2(TMAX) + 1;

    state_t          state;
    state_t          next_state;
    logic            ld;
    logic [TW-1:0]   ld_val;
    logic            zero;

    gate_timer #(.W(TW)) u_timer (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .LD     (ld),
        .LD_VAL (ld_val),
        .ZERO   (zero)
    );

    // Each timed state is entered with its length minus one loaded, so it exits on zero.
    always_comb begin
        next_state = state;
        ld         = 1'b0;
        ld_val     = '0;
        case (state)
            IDLE: begin
                if (START) begin
                    next_state = CLEAR;
                    ld         = 1'b1;
                    ld_val     = TW'(CLR_CYCLES - 1);
                end
            end
            CLEAR: begin
                if (zero) begin
                    next_state = GATE;
                    ld         = 1'b1;
                    ld_val     = TW'(GATE_CYCLES - 1);
                end
            end
            GATE: begin
                if (zero) begin
                    next_state = SETTLE;
                    ld         = 1'b1;
                    ld_val     = TW'(SETTLE_CYCLES - 1);
                end
            end
            SETTLE: begin
                if (zero) next_state = LATCH;
            end
            LATCH: begin
                next_state = HOLD;
                ld         = 1'b1;
                ld_val     = TW'(HOLD_CYCLES - 1);
            end
            HOLD: begin
                if (zero) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from next_state into flops so they line up with the state register.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= IDLE;
            ENA     <= 1'b0;
            CLR     <= 1'b0;
            LOAD    <= 1'b0;
            VALID   <= 1'b0;
            BUSY    <= 1'b0;
            Q_LATCH <= '0;
        end else begin
            state <= next_state;
            ENA   <= (next_state == GATE);
            CLR   <= (next_state == CLEAR);
            LOAD  <= (next_state == LATCH);
            VALID <= (state == LATCH);
            BUSY  <= (next_state != IDLE);
`ifdef FREQ_GATE_BCD_CHECK_EN
            if (state == LATCH && bcd_ok(Q_IN)) Q_LATCH <= Q_IN;
`else
            if (state == LATCH) Q_LATCH <= Q_IN;
`endif
        end
    end

`ifdef FREQ_GATE_BCD_CHECK_EN
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            ERR <= 1'b0;
        end else if (state == LATCH) begin
            ERR <= !bcd_ok(Q_IN);
        end
    end
`else
    assign ERR = 1'b0;
`endif

endmodule

// File: doc/freq_gate_ctrl.md
Name: freq_gate_ctrl

Overview:
- Control end of the 6-digit BCD frequency-counter interface: drives ENA and CLR into the counter, then captures its 24-bit BCD result Q.
- Runs a measurement cycle: clear the counter, open a fixed gate window, close it, let the count settle, then latch the count.
- Presents the latched result with a one-cycle VALID strobe; sits between the counter and the display/readout logic.

Parameters:
- CLR_CYCLES, 4, cycles CLR held high per measurement (>=1)
- GATE_CYCLES, 80, cycles ENA held high (gate window, >=1)
- SETTLE_CYCLES, 2, cycles after ENA falls before Q_IN is sampled (>=1)
- HOLD_CYCLES, 10, cycles after latch before the next measurement may start (>=1)

Ports:
- CLK  in  1  system clock, rising-edge
- RST_N  in  1  synchronous active-low reset
- START  in  1  request measurement; level-sensitive, sampled in IDLE
- Q_IN  in  24  BCD count from counter, 6 nibbles, [3:0] = units
- ENA  out  1  counter enable (gate)
- CLR  out  1  counter clear
- LOAD  out  1  one-cycle pulse, the cycle Q_IN is captured
- Q_LATCH  out  24  last captured BCD count
- VALID  out  1  one-cycle pulse, the cycle after LOAD, when Q_LATCH is new
- BUSY  out  1  high in every state except IDLE
- ERR  out  1  BCD-format error flag (see Optional Feature)

Behaviour:
- Reset: when RST_N=0 at a CLK edge, the block goes to IDLE. All outputs become 0: ENA, CLR, LOAD, VALID, BUSY, ERR and Q_LATCH=24'h0. The timer becomes 0.
- Reset mid-measurement aborts immediately; Q_LATCH is cleared and no VALID is issued.
- The FSM is registered and all outputs are registered (Moore). The states and transitions are:
  - IDLE: outputs low. If START=1, go to CLEAR and load the timer with CLR_CYCLES-1.
  - CLEAR: CLR=1, ENA=0, for exactly CLR_CYCLES cycles, then go to GATE and load GATE_CYCLES-1.
  - GATE: CLR=0, ENA=1, for exactly GATE_CYCLES cycles, then go to SETTLE and load SETTLE_CYCLES-1.
  - SETTLE: ENA=0 for SETTLE_CYCLES cycles, then go to LATCH.
  - LATCH: 1 cycle. LOAD=1; Q_LATCH<=Q_IN at the end of the cycle. Then go to HOLD and load HOLD_CYCLES-1.
  - HOLD: VALID=1 in the first HOLD cycle only. After HOLD_CYCLES cycles, return to IDLE.
- A START held high continuously gives back-to-back measurements with period CLR+GATE+SETTLE+1+HOLD+1 cycles. The +1 after HOLD is the IDLE cycle.
- START toggling while not in IDLE is ignored and not queued.
- ENA and CLR are never high in the same cycle. ENA is high for exactly GATE_CYCLES cycles per measurement.
- The timer is a down-counter sized $clog2(max parameter)+1 bits. Each state exits on timer==0; there is no wrap.
- Q_LATCH holds its value until the next LATCH or reset. It is never updated in any other state.
- BUSY=1 from the first CLEAR cycle through the last HOLD cycle.

Optional Feature:
- Macro: FREQ_GATE_BCD_CHECK_EN.
- Defined:
  - In LATCH, each of the 6 nibbles of Q_IN is checked for <=9.
  - If any nibble is >9: ERR<=1, Q_LATCH keeps its old value, and VALID is still pulsed in HOLD.
  - If all nibbles are valid: ERR<=0 and Q_LATCH is updated.
  - ERR holds its value until the next LATCH or reset.
- Not defined: ERR is tied to 0, and Q_LATCH is always updated in LATCH.

Decomposition:
- Package freq_meter_pkg holds:
  - the state enum (IDLE, CLEAR, GATE, SETTLE, LATCH, HOLD)
  - BCD_DIGITS=6
  - Q_W=24 (BCD_DIGITS*4)
  - the nibble limit constant 4'd9
- Sub-module gate_timer: loadable down-counter with ports CLK, RST_N, LD, LD_VAL, ZERO. The FSM instantiates it once.

Test Plan:
- Reset then START=1 for 1 cycle with default parameters:
  - CLR high 4 cycles, then ENA high exactly 80 cycles, then 2 settle cycles.
  - LOAD pulses on the 87th cycle after entering CLEAR; VALID pulses 1 cycle later.
  - Q_IN=24'h000080 is latched, so Q_LATCH=24'h000080.
- START held high: two measurements back-to-back. The second CLR rises exactly 98 cycles after the first CLR rose; BUSY low for exactly 1 cycle in between.
- RST_N=0 during cycle 40 of GATE: next edge ENA=0, BUSY=0, Q_LATCH=0; no LOAD/VALID follows until a new START.
- START pulses during GATE and HOLD: the pulses are ignored, and the block returns to IDLE and stays there with START=0.
- With FREQ_GATE_BCD_CHECK_EN defined:
  - Q_IN=24'h00A123 at LATCH: ERR=1 and Q_LATCH keeps its previous value 24'h000080.
  - Next run with Q_IN=24'h000123: ERR=0 and Q_LATCH=24'h000123.
- Parameter override CLR_CYCLES=1, GATE_CYCLES=1, SETTLE_CYCLES=1, HOLD_CYCLES=1: CLR 1 cycle, ENA 1 cycle, LOAD 2 cycles after ENA rises; ENA and CLR never overlap.
